// File: rtl/seq_pkg.sv
// Shared encodings for the accumulator-datapath instruction sequencer:
// opcodes, register selects, ALU codes, write-back sources and FSM states.
package seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_MC  = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b101;
  localparam logic [2:0] OP_MR  = 3'b110;
  localparam logic [2:0] OP_MW  = 3'b111;

  localparam logic [1:0] SEL_REG_A = 2'b00;
  localparam logic [1:0] SEL_REG_B = 2'b01;
  localparam logic [1:0] SEL_ACC   = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_DIV  = 4'b0001;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_EXEC     = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_HALT     = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  src;
    logic [1:0]  dest;
    logic [24:0] imm;
  } inst_t;

  // A load into the ZERO code has no real register behind it, so it lands in acc.
  function automatic logic [1:0] load_target(input logic [1:0] dest);
    logic [1:0] sel;
    case (dest)
      SEL_REG_A: sel = SEL_REG_A;
      SEL_REG_B: sel = SEL_REG_B;
      default:   sel = SEL_ACC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational field decode: opcode/src/dest to ALU operation, operand
// selects and the load write target.
module seq_decode
  import seq_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] src,
  input  logic [1:0] dest,
  output logic [3:0] alu_op,
  output logic       b_zero,
  output logic [1:0] rd_sel,
  output logic [1:0] ld_sel
);

  // ALU operation code for the four arithmetic opcodes; everything else idles the ALU.
  always_comb begin
    alu_op = ALU_NONE;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_DIV:  alu_op = ALU_DIV;
      OP_MUL:  alu_op = ALU_MUL;
      default: alu_op = ALU_NONE;
    endcase
  end

  assign b_zero = (src == SEL_ZERO);
  assign rd_sel = src;
  assign ld_sel = load_target(dest);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetches one instruction per handshake and drives
// register-bank, ALU and data-memory control lines cycle by cycle.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int ADDR_W    = 25,
  parameter int MEM_WORDS = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  output logic              inst_ready,
  output logic [PC_W-1:0]   pc,
  output logic [1:0]        rb_rd_sel,
  output logic              rb_wr_en,
  output logic [1:0]        rb_wr_sel,
  output logic              wb_src,
  output logic [3:0]        alu_op,
  output logic              alu_b_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rd_valid,
  output logic              mem_wr,
  output logic              mem_wdata_zero,
  output logic              halted,
  output logic              retire
);

  state_e            state_r;
  logic [PC_W-1:0]   pc_r;
  inst_t             ir_r;
  logic [ADDR_W-1:0] clr_cnt_r;

  logic [3:0]        dec_alu_op_s;
  logic              dec_b_zero_s;
  logic [1:0]        dec_rd_sel_s;
  logic [1:0]        dec_ld_sel_s;
  logic [ADDR_W-1:0] imm_addr_s;
  logic              clr_last_s;

  seq_decode u_decode (
    .opcode (ir_r.opcode),
    .src    (ir_r.src),
    .dest   (ir_r.dest),
    .alu_op (dec_alu_op_s),
    .b_zero (dec_b_zero_s),
    .rd_sel (dec_rd_sel_s),
    .ld_sel (dec_ld_sel_s)
  );

  assign imm_addr_s = ADDR_W'(ir_r.imm);
  assign clr_last_s = (clr_cnt_r == ADDR_W'(MEM_WORDS - 1));
  assign pc         = RST ? {PC_W{1'b0}} : pc_r;

  // State, program counter, instruction register and clear counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_FETCH;
      pc_r      <= {PC_W{1'b0}};
      ir_r      <= inst_t'(32'h0000_0000);
      clr_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (inst_valid) begin
            ir_r    <= inst_t'(inst);
            pc_r    <= pc_r + PC_W'(1'b1);
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ir_r.opcode)
            OP_MR:   state_r <= ST_MEM_WAIT;
            OP_MC: begin
              clr_cnt_r <= {ADDR_W{1'b0}};
              state_r   <= ST_CLEAR;
            end
            OP_HLT:  state_r <= ST_HALT;
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEM_WAIT: begin
          if (mem_rd_valid) begin
            state_r <= ST_FETCH;
          end
        end
        ST_CLEAR: begin
          if (clr_last_s) begin
            state_r <= ST_FETCH;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1'b1);
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Output decode from the registered state; the reset cycle forces every output low.
  always_comb begin
    inst_ready     = 1'b0;
    rb_rd_sel      = SEL_REG_A;
    rb_wr_en       = 1'b0;
    rb_wr_sel      = SEL_REG_A;
    wb_src         = WB_ALU;
    alu_op         = ALU_NONE;
    alu_b_zero     = 1'b0;
    mem_addr       = {ADDR_W{1'b0}};
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_wdata_zero = 1'b0;
    halted         = 1'b0;
    retire         = 1'b0;
    if (RST) begin
      inst_ready = 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: inst_ready = 1'b1;
        ST_EXEC: begin
          case (ir_r.opcode)
            OP_ADD, OP_SUB, OP_DIV, OP_MUL: begin
              rb_rd_sel  = dec_rd_sel_s;
              alu_b_zero = dec_b_zero_s;
              alu_op     = dec_alu_op_s;
              wb_src     = WB_ALU;
              rb_wr_en   = 1'b1;
              rb_wr_sel  = SEL_ACC;
              retire     = 1'b1;
            end
            OP_MR: begin
              mem_addr = imm_addr_s;
              mem_rd   = 1'b1;
            end
            OP_MW: begin
              mem_addr       = imm_addr_s;
              mem_wr         = 1'b1;
              rb_rd_sel      = dec_rd_sel_s;
              mem_wdata_zero = dec_b_zero_s;
              retire         = 1'b1;
            end
            OP_HLT:  retire = 1'b1;
            default: retire = 1'b0;
          endcase
        end
        ST_MEM_WAIT: begin
          mem_addr = imm_addr_s;
          if (mem_rd_valid) begin
            wb_src    = WB_MEM;
            rb_wr_en  = 1'b1;
            rb_wr_sel = dec_ld_sel_s;
            retire    = 1'b1;
          end else begin
            rb_wr_en = 1'b0;
          end
        end
        ST_CLEAR: begin
          mem_wr         = 1'b1;
          mem_addr       = clr_cnt_r;
          mem_wdata_zero = 1'b1;
          retire         = clr_last_s;
        end
        ST_HALT: halted = 1'b1;
        default: inst_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench: stimulus pushes expected strobe events, a monitor
// pops and compares them whenever the sequencer raises any strobe.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        mem_rd_valid = 1'b0;
  logic        inst_ready;
  logic [7:0]  pc;
  logic [1:0]  rb_rd_sel;
  logic        rb_wr_en;
  logic [1:0]  rb_wr_sel;
  logic        wb_src;
  logic [3:0]  alu_op;
  logic        alu_b_zero;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_wdata_zero;
  logic        halted;
  logic        retire;

  typedef struct packed {
    logic        we;
    logic [1:0]  ws;
    logic [1:0]  rs;
    logic        wb;
    logic [3:0]  op;
    logic        bz;
    logic [24:0] addr;
    logic        rd;
    logic        wr;
    logic        wz;
    logic        ret;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        got_ev;
  ev_t        want_ev;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pc = 8'h00;

  instr_sequencer #(.PC_W(8), .ADDR_W(25), .MEM_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .inst_valid(inst_valid), .inst(inst),
    .inst_ready(inst_ready), .pc(pc), .rb_rd_sel(rb_rd_sel),
    .rb_wr_en(rb_wr_en), .rb_wr_sel(rb_wr_sel), .wb_src(wb_src),
    .alu_op(alu_op), .alu_b_zero(alu_b_zero), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rd_valid(mem_rd_valid), .mem_wr(mem_wr),
    .mem_wdata_zero(mem_wdata_zero), .halted(halted), .retire(retire)
  );

  always #5 CLK = ~CLK;

  function automatic ev_t mk(input logic we, input logic [1:0] ws, input logic [1:0] rs,
                             input logic wb, input logic [3:0] op, input logic bz,
                             input logic [24:0] addr, input logic rd, input logic wr,
                             input logic wz, input logic ret);
    ev_t e;
    e = {we, ws, rs, wb, op, bz, addr, rd, wr, wz, ret};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    while (inst_ready !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ready_before_send", {31'h0, inst_ready}, 32'h1);
    inst = w;
    inst_valid = 1'b1;
    @(posedge CLK); #1;
    inst_valid = 1'b0;
    inst = 32'h0;
    exp_pc = exp_pc + 8'h01;
    chk("pc_after_accept", {24'h0, pc}, {24'h0, exp_pc});
  endtask

  // Monitor: every strobe cycle must match the oldest expected event.
  initial begin
    forever begin
      @(negedge CLK);
      if (rb_wr_en || mem_wr || mem_rd || retire) begin
        got_ev = {rb_wr_en, rb_wr_sel, rb_rd_sel, wb_src, alu_op, alu_b_zero,
                  mem_addr, mem_rd, mem_wr, mem_wdata_zero, retire};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: got %h expected no strobe", got_ev);
        end else begin
          want_ev = exp_q.pop_front();
          if (got_ev !== want_ev) begin
            errors++;
            $display("FAIL strobe_event: got %h expected %h", got_ev, want_ev);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge CLK); #1;
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_ready", {31'h0, inst_ready}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("post_rst_ready", {31'h0, inst_ready}, 32'h1);
    chk("post_rst_pc", {24'h0, pc}, 32'h0);

    // ALU ops: ADD reg_a, SUB reg_b, MUL zero, DIV acc
    exp_q.push_back(mk(1'b1, 2'b10, 2'b00, 1'b0, 4'b1000, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h0000_0000);
    exp_q.push_back(mk(1'b1, 2'b10, 2'b01, 1'b0, 4'b0100, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h2800_0000);
    exp_q.push_back(mk(1'b1, 2'b10, 2'b11, 1'b0, 4'b0010, 1'b1, 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h7800_0000);
    exp_q.push_back(mk(1'b1, 2'b10, 2'b10, 1'b0, 4'b0001, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'h5000_0000);

    // MR into reg_b at address 5, read data three cycles late
    exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 25'h5, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 2'b01, 2'b00, 1'b1, 4'b0000, 1'b0, 25'h5, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'hC200_0005);
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_wait_ready", {31'h0, inst_ready}, 32'h0);
      chk("mr_wait_addr", {7'h0, mem_addr}, 32'h5);
      @(posedge CLK); #1;
    end
    mem_rd_valid = 1'b1;
    #1;
    chk("mr_valid_ready", {31'h0, inst_ready}, 32'h0);
    @(posedge CLK); #1;
    mem_rd_valid = 1'b0;

    // MR with dest code 11 lands in acc, data valid immediately
    exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 25'h9, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 2'b10, 2'b00, 1'b1, 4'b0000, 1'b0, 25'h9, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'hC600_0009);
    @(posedge CLK); #1;
    mem_rd_valid = 1'b1;
    @(posedge CLK); #1;
    mem_rd_valid = 1'b0;

    // MW of zero to 0x10
    exp_q.push_back(mk(1'b0, 2'b00, 2'b11, 1'b0, 4'b0000, 1'b0, 25'h10, 1'b0, 1'b1, 1'b1, 1'b1));
    send(32'hF800_0010);

    // MC over four words
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 25'(i), 1'b0, 1'b1, 1'b1, (i == 3)));
    end
    send(32'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("mc_busy_ready", {31'h0, inst_ready}, 32'h0);
    end
    @(posedge CLK); #1;
    chk("mc_done_ready", {31'h0, inst_ready}, 32'h1);

    // HLT with inst_valid held high, then reset out of HALT
    exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    send(32'hA000_0000);
    @(posedge CLK); #1;
    inst = 32'h0000_0000;
    inst_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", {31'h0, halted}, 32'h1);
      chk("halt_ready", {31'h0, inst_ready}, 32'h0);
      chk("halt_pc", {24'h0, pc}, {24'h0, exp_pc});
      @(posedge CLK); #1;
    end
    inst_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("halt_rst_pc", {24'h0, pc}, 32'h0);
    chk("halt_rst_halted", {31'h0, halted}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    exp_pc = 8'h00;
    chk("halt_exit_ready", {31'h0, inst_ready}, 32'h1);
    chk("halt_exit_pc", {24'h0, pc}, 32'h0);

    // Reset in MEM_WAIT coinciding with read data: no write-back
    exp_q.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, 1'b0, 25'h5, 1'b1, 1'b0, 1'b0, 1'b0));
    send(32'hC400_0005);
    @(posedge CLK); #1;
    RST = 1'b1;
    mem_rd_valid = 1'b1;
    #1;
    chk("rst_wait_wr_en", {31'h0, rb_wr_en}, 32'h0);
    chk("rst_wait_retire", {31'h0, retire}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    mem_rd_valid = 1'b0;
    #1;
    exp_pc = 8'h00;
    chk("rst_wait_fetch", {31'h0, inst_ready}, 32'h1);
    chk("rst_wait_pc", {24'h0, pc}, 32'h0);

    // 256 ALU instructions: pc runs 0x01..0xFF and wraps to 0x00
    for (int i = 0; i < 256; i++) begin
      logic [1:0] s;
      s = 2'(i);
      exp_q.push_back(mk(1'b1, 2'b10, s, 1'b0, 4'b1000, (s == 2'b11), 25'h0, 1'b0, 1'b0, 1'b0, 1'b1));
      send({3'b000, s, 2'b00, 25'h0});
    end
    chk("pc_wrapped", {24'h0, pc}, 32'h0);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
